fetch_stage: RTL and testbench
==============================

# fetch_stage

Stage-I instruction fetch for the Riscv151 three-stage pipeline, directly upstream of `control`. Owns the PC, issues one instruction-cache read per cycle and presents the returned word and its PC to decode. Applies the `PC_Sel` redirect and `Inst_Kill` squash that `control` produces. Absorbs I-cache miss latency and downstream stalls by inserting NOP bubbles or holding its output.

## Interface
- `RESET_PC`, 32'h0000_2000: first fetch address after reset.
- `NOP_INST`, 32'h0000_0013: bubble encoding (`addi x0,x0,0`).
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high.
- `PC_Sel` in 2: 2'd0 = PC+4, 2'd1 = ALU target; other codes are treated as PC+4.
- `alu_target` in 32: redirect address, used when `PC_Sel` = 2'd1.
- `Inst_Kill` in 1: the word currently on `inst` is wrong-path.
- `stall` in 1: downstream cannot accept a new instruction this cycle.
- `icache_addr` out 32: read address, combinational.
- `icache_re` out 1: read request.
- `icache_valid` in 1: `icache_dout` holds the word for the previous accepted address.
- `icache_dout` in 32: instruction word.
- `inst` out 32: instruction to decode.
- `pc_I` out 32: PC of `inst`.
- `inst_valid` out 1: `inst` is a real instruction, not a bubble.

## Operation
- FSM states:
  - BOOT: one cycle after reset release. Requests `RESET_PC`. Outputs a bubble.
  - RUN: normal fetch.
  - MISS: the previous request has not returned (`icache_valid` = 0).
  - HOLD: downstream is stalled and a captured word is being held.
- Registers:
  - `pc_q`: address of the outstanding request.
  - `hold_inst`, `hold_pc`: captured word and its PC.
  - `redir_pend`, `redir_tgt`: a redirect that arrived while the fetch could not advance.
- Next address, highest priority first:
  1. BOOT → `RESET_PC`.
  2. `stall` or MISS → `pc_q` (re-request the same address).
  3. `redir_pend` → `redir_tgt`.
  4. `PC_Sel` = 2'd1 → `alu_target`.
  5. Otherwise → `pc_q` + 4.
- PC arithmetic: unsigned, modulo 2^32. 32'hFFFF_FFFC + 4 wraps to 0. Bits [1:0] of any target are forced to 0.
- RUN:
  - `icache_valid` = 1 and no stall: `inst` = `icache_dout`, `pc_I` = `pc_q`, `inst_valid` = 1.
  - `icache_valid` = 0: go to MISS. Output a bubble (`NOP_INST`, `inst_valid` = 0).
  - `stall` = 1 with valid data: capture into `hold_inst`/`hold_pc` and go to HOLD.
- MISS:
  - Output a bubble; keep `icache_addr` = `pc_q`.
  - Return to RUN on `icache_valid` and emit the word.
  - If `PC_Sel` = 2'd1 arrives while in MISS, latch `redir_pend`/`redir_tgt`. The word that eventually returns is discarded (bubble), then the target is requested.
- HOLD:
  - Output `hold_inst`/`hold_pc` unchanged.
  - The re-request of `pc_q` continues so data is fresh on exit.
  - Leave on `stall` = 0.
- `Inst_Kill` = 1: this cycle's `inst` is replaced by `NOP_INST` with `inst_valid` = 0, regardless of state. Kill never modifies `pc_q`.
- Simultaneous `stall` and redirect: stall wins. The redirect is taken on the first non-stalled cycle; `control` holds `PC_Sel` while stalled.
- Simultaneous `Inst_Kill` and `stall`: the held word is marked killed (`inst_valid` stays 0 until HOLD exits).

## Timing
- Reset (asynchronous, immediate):
  - State = BOOT, `pc_q` = `RESET_PC`, `redir_pend` = 0.
  - `icache_re` = 0, `icache_addr` = `RESET_PC`.
  - `inst` = `NOP_INST`, `pc_I` = `RESET_PC`, `inst_valid` = 0.
- `icache_re` = 1 in every non-reset cycle.
- I-cache contract: address in cycle N; data with `icache_valid` in cycle N+1 on a hit, or later on a miss.
- First valid instruction: two cycles after reset release (BOOT request, then RUN data).
- Steady-state throughput: one instruction per cycle.
- Redirect penalty:
  - Target word appears one cycle after `PC_Sel` = 2'd1 is sampled.
  - The single in-flight wrong-path word is squashed by `Inst_Kill`.
- Reset asserted mid-MISS or mid-HOLD: all pending state is dropped; restart from BOOT.

## Configuration
- `FETCH_PERF_EN`:
  - Defined: adds outputs `fetch_count` (32) and `kill_count` (32), both reset to 0.
  - `fetch_count` increments on each `inst_valid` cycle not stalled.
  - `kill_count` increments on each cycle with `Inst_Kill` = 1.
  - Both counters wrap modulo 2^32.
  - Undefined: neither port nor counters exist; behaviour is otherwise identical.

## Test plan
- Reset release, I-cache always hits with word = address → `icache_addr` 0x2000, 0x2004, 0x2008…; `inst` = 0x2000 with `inst_valid` = 1 on the second cycle after release.
- `PC_Sel` = 1, `alu_target` = 0x3001, `Inst_Kill` = 1 the next cycle → wrong-path word has `inst_valid` = 0; next `pc_I` = 0x3000.
- `icache_valid` low for 3 cycles on 0x2008 → 3 bubbles, `icache_addr` held at 0x2008, then `inst` = 0x2008.
- `stall` high for 2 cycles during RUN → `inst`/`pc_I` unchanged for both cycles; no fetched word lost or duplicated on release.
- Redirect to 0x4000 during a MISS on 0x200C → 0x200C word discarded; next valid `pc_I` = 0x4000.
- `reset` pulsed mid-HOLD → outputs immediately return to `NOP_INST` / `RESET_PC`; with `FETCH_PERF_EN`, both counters read 0.

Source files
------------

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - I-cache request/response bus between fetch and the instruction cache
// Purpose: groups the one-request-per-cycle I-cache port of fetch_stage.
// Signals:
//   icache_addr   read address (fetch -> cache)
//   icache_re     read request (fetch -> cache)
//   icache_valid  icache_dout holds the word for the previously accepted address (cache -> fetch)
//   icache_dout   instruction word (cache -> fetch)
// Modports: master = fetch side, slave = cache side.
interface fetch_stage_if;
  logic [31:0] icache_addr;
  logic        icache_re;
  logic        icache_valid;
  logic [31:0] icache_dout;

  modport master (
    output icache_addr,
    output icache_re,
    input  icache_valid,
    input  icache_dout
  );

  modport slave (
    input  icache_addr,
    input  icache_re,
    output icache_valid,
    output icache_dout
  );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - Riscv151 stage-I instruction fetch
// Purpose: owns the PC, issues one I-cache read per cycle and presents the
//   returned word with its PC to decode. Applies PC_Sel redirects and
//   Inst_Kill squashes, inserts bubbles on I-cache misses and holds its
//   output while decode is stalled.
// Ports:
//   clk, reset               clock; asynchronous active-high reset
//   PC_Sel, alu_target       redirect select (2'd1 = ALU target) and address
//   Inst_Kill                squash the word currently on inst
//   stall                    decode cannot accept a new instruction
//   icache                   I-cache bus (fetch_stage_if.master)
//   inst, pc_I, inst_valid   instruction, its PC, real-instruction flag
//   fetch_count, kill_count  performance counters (FETCH_PERF_EN only)
// Options: define FETCH_PERF_EN to add the two performance counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_2000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    PC_Sel,
  input  logic [31:0]   alu_target,
  input  logic          Inst_Kill,
  input  logic          stall,
  fetch_stage_if.master icache,
  output logic [31:0]   inst,
  output logic [31:0]   pc_I,
  output logic          inst_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]   fetch_count,
  output logic [31:0]   kill_count
`endif
);

  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, MISS = 2'd2, HOLD = 2'd3} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_inst_q, hold_inst_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic        hold_kill_q, hold_kill_d;
  logic        redir_pend_q, redir_pend_d;
  logic [31:0] redir_tgt_q, redir_tgt_d;

  logic fetching;   // a request is outstanding and its response matters
  logic wait_mem;   // outstanding request has not returned yet
  logic take_word;  // returned word is on the correct path and can be emitted
  logic redir_now;

  assign fetching  = (state_q == RUN) || (state_q == MISS);
  assign wait_mem  = fetching && !icache.icache_valid;
  assign take_word = fetching && icache.icache_valid && !redir_pend_q;
  assign redir_now = (PC_Sel == 2'd1);

  // Request is combinational so a redirect reaches the cache in the same cycle.
  assign icache.icache_addr = pc_d;
  assign icache.icache_re   = !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      hold_inst_q  <= NOP_INST;
      hold_pc_q    <= RESET_PC;
      hold_kill_q  <= 1'b0;
      redir_pend_q <= 1'b0;
      redir_tgt_q  <= RESET_PC;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_inst_q  <= hold_inst_d;
      hold_pc_q    <= hold_pc_d;
      hold_kill_q  <= hold_kill_d;
      redir_pend_q <= redir_pend_d;
      redir_tgt_q  <= redir_tgt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN, MISS: begin
        if (!icache.icache_valid)     state_d = MISS;
        else if (take_word && stall)  state_d = HOLD;
        else                          state_d = RUN;
      end
      HOLD:    state_d = stall ? HOLD : RUN;
      default: state_d = BOOT;
    endcase
  end

  // Next address and side registers. Stall and an outstanding miss both pin
  // the request to pc_q; a redirect seen during a miss is parked until the
  // stale word returns, since the cache only tracks one request.
  always_comb begin
    pc_d         = pc_q + 32'd4;
    redir_pend_d = redir_pend_q;
    redir_tgt_d  = redir_tgt_q;
    hold_inst_d  = hold_inst_q;
    hold_pc_d    = hold_pc_q;
    hold_kill_d  = hold_kill_q;

    if (state_q == BOOT) begin
      pc_d = RESET_PC;
    end else if (stall || wait_mem) begin
      pc_d = pc_q;
      if (wait_mem && redir_now && !redir_pend_q) begin
        redir_pend_d = 1'b1;
        redir_tgt_d  = alu_target & ~32'd3;
      end
    end else if (redir_pend_q) begin
      pc_d         = redir_tgt_q;
      redir_pend_d = 1'b0;
    end else if (redir_now) begin
      pc_d = alu_target & ~32'd3;
    end

    // A kill while stalled sticks to the held copy until HOLD is left.
    if (take_word && stall) begin
      hold_inst_d = icache.icache_dout;
      hold_pc_d   = pc_q;
      hold_kill_d = Inst_Kill;
    end else if (state_q == HOLD) begin
      hold_kill_d = hold_kill_q || Inst_Kill;
    end
  end

  always_comb begin
    inst       = NOP_INST;
    pc_I       = pc_q;
    inst_valid = 1'b0;
    case (state_q)
      RUN, MISS: begin
        if (take_word) begin
          inst       = icache.icache_dout;
          inst_valid = 1'b1;
        end
      end
      HOLD: begin
        pc_I = hold_pc_q;
        if (!hold_kill_q) begin
          inst       = hold_inst_q;
          inst_valid = 1'b1;
        end
      end
      default: ;
    endcase
    if (Inst_Kill) begin
      inst       = NOP_INST;
      inst_valid = 1'b0;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count <= 32'd0;
      kill_count  <= 32'd0;
    end else begin
      if (inst_valid && !stall) fetch_count <= fetch_count + 32'd1;
      if (Inst_Kill)            kill_count  <= kill_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic [1:0]  PC_Sel;
  logic [31:0] alu_target;
  logic        Inst_Kill;
  logic        stall;
  logic [31:0] inst;
  logic [31:0] pc_I;
  logic        inst_valid;
  logic        force_miss;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] kill_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  fetch_stage_if ic();

  fetch_stage dut (
    .clk        (clk),
    .reset      (reset),
    .PC_Sel     (PC_Sel),
    .alu_target (alu_target),
    .Inst_Kill  (Inst_Kill),
    .stall      (stall),
    .icache     (ic),
    .inst       (inst),
    .pc_I       (pc_I),
    .inst_valid (inst_valid)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count(fetch_count),
    .kill_count (kill_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // I-cache: word = address, one-cycle hit latency, misses forced by the bench.
  always @(posedge clk) begin
    ic.icache_dout  <= ic.icache_addr;
    ic.icache_valid <= ic.icache_re && !force_miss;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; PC_Sel = 2'd0; alu_target = 32'd0; Inst_Kill = 1'b0; stall = 1'b0; force_miss = 1'b0;
    #2;
    n_cmp++; if (ic.icache_re !== 1'b0) begin n_bad++; $display("FAIL rst_re: got %b want 0", ic.icache_re); end
    n_cmp++; if (ic.icache_addr !== 32'h2000) begin n_bad++; $display("FAIL rst_addr: got %h want 00002000", ic.icache_addr); end
    n_cmp++; if (inst !== NOP) begin n_bad++; $display("FAIL rst_inst: got %h want %h", inst, NOP); end
    n_cmp++; if (pc_I !== 32'h2000) begin n_bad++; $display("FAIL rst_pc: got %h want 00002000", pc_I); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", inst_valid); end
`ifdef FETCH_PERF_EN
    n_cmp++; if (fetch_count !== 32'd0) begin n_bad++; $display("FAIL rst_fcnt: got %0d want 0", fetch_count); end
    n_cmp++; if (kill_count !== 32'd0) begin n_bad++; $display("FAIL rst_kcnt: got %0d want 0", kill_count); end
`endif
    tick(); reset = 1'b0; #1;
    n_cmp++; if (ic.icache_re !== 1'b1) begin n_bad++; $display("FAIL boot_re: got %b want 1", ic.icache_re); end
    n_cmp++; if (ic.icache_addr !== 32'h2000) begin n_bad++; $display("FAIL boot_addr: got %h want 00002000", ic.icache_addr); end
    n_cmp++; if (inst_valid !== 1'b0 || inst !== NOP) begin n_bad++; $display("FAIL boot_bubble: got %h/%b want %h/0", inst, inst_valid, NOP); end
  endtask

  task automatic test_sequential();
    tick(); #1;
    n_cmp++; if (inst !== 32'h2000 || inst_valid !== 1'b1) begin n_bad++; $display("FAIL seq_inst0: got %h/%b want 00002000/1", inst, inst_valid); end
    n_cmp++; if (pc_I !== 32'h2000) begin n_bad++; $display("FAIL seq_pc0: got %h want 00002000", pc_I); end
    n_cmp++; if (ic.icache_addr !== 32'h2004) begin n_bad++; $display("FAIL seq_addr1: got %h want 00002004", ic.icache_addr); end
  endtask

  task automatic test_miss();
    tick(); force_miss = 1'b1; #1;
    n_cmp++; if (inst !== 32'h2004 || inst_valid !== 1'b1) begin n_bad++; $display("FAIL seq_inst1: got %h/%b want 00002004/1", inst, inst_valid); end
    n_cmp++; if (ic.icache_addr !== 32'h2008) begin n_bad++; $display("FAIL seq_addr2: got %h want 00002008", ic.icache_addr); end
    for (int i = 0; i < 3; i++) begin
      tick(); if (i == 2) force_miss = 1'b0; #1;
      n_cmp++; if (inst_valid !== 1'b0 || inst !== NOP) begin n_bad++; $display("FAIL miss_bubble%0d: got %h/%b want %h/0", i, inst, inst_valid, NOP); end
      n_cmp++; if (ic.icache_addr !== 32'h2008) begin n_bad++; $display("FAIL miss_addr%0d: got %h want 00002008", i, ic.icache_addr); end
      n_cmp++; if (ic.icache_re !== 1'b1) begin n_bad++; $display("FAIL miss_re%0d: got %b want 1", i, ic.icache_re); end
    end
    tick(); #1;
    n_cmp++; if (inst !== 32'h2008 || inst_valid !== 1'b1 || pc_I !== 32'h2008) begin n_bad++; $display("FAIL miss_done: got %h/%b pc %h want 00002008/1 pc 00002008", inst, inst_valid, pc_I); end
    n_cmp++; if (ic.icache_addr !== 32'h200C) begin n_bad++; $display("FAIL miss_next: got %h want 0000200c", ic.icache_addr); end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 2; i++) begin
      tick(); stall = 1'b1; #1;
      n_cmp++; if (inst !== 32'h200C || pc_I !== 32'h200C || inst_valid !== 1'b1) begin n_bad++; $display("FAIL stall_hold%0d: got %h pc %h v %b want 0000200c pc 0000200c v 1", i, inst, pc_I, inst_valid); end
      n_cmp++; if (ic.icache_addr !== 32'h200C) begin n_bad++; $display("FAIL stall_addr%0d: got %h want 0000200c", i, ic.icache_addr); end
    end
    tick(); stall = 1'b0; #1;
    n_cmp++; if (inst !== 32'h200C || pc_I !== 32'h200C || inst_valid !== 1'b1) begin n_bad++; $display("FAIL stall_exit: got %h pc %h v %b want 0000200c pc 0000200c v 1", inst, pc_I, inst_valid); end
    n_cmp++; if (ic.icache_addr !== 32'h2010) begin n_bad++; $display("FAIL stall_exit_addr: got %h want 00002010", ic.icache_addr); end
    tick(); #1;
    n_cmp++; if (inst !== 32'h2010 || pc_I !== 32'h2010 || inst_valid !== 1'b1) begin n_bad++; $display("FAIL stall_after: got %h pc %h v %b want 00002010 pc 00002010 v 1", inst, pc_I, inst_valid); end
  endtask

  task automatic test_redirect();
    tick(); PC_Sel = 2'd1; alu_target = 32'h3001; Inst_Kill = 1'b1; #1;
    n_cmp++; if (inst_valid !== 1'b0 || inst !== NOP) begin n_bad++; $display("FAIL redir_kill: got %h/%b want %h/0", inst, inst_valid, NOP); end
    n_cmp++; if (ic.icache_addr !== 32'h3000) begin n_bad++; $display("FAIL redir_addr: got %h want 00003000", ic.icache_addr); end
    tick(); PC_Sel = 2'd0; alu_target = 32'd0; Inst_Kill = 1'b0; #1;
    n_cmp++; if (pc_I !== 32'h3000 || inst !== 32'h3000 || inst_valid !== 1'b1) begin n_bad++; $display("FAIL redir_target: got %h pc %h v %b want 00003000 pc 00003000 v 1", inst, pc_I, inst_valid); end
    n_cmp++; if (ic.icache_addr !== 32'h3004) begin n_bad++; $display("FAIL redir_next: got %h want 00003004", ic.icache_addr); end
  endtask

  task automatic test_kill();
    tick(); Inst_Kill = 1'b1; #1;
    n_cmp++; if (inst_valid !== 1'b0 || inst !== NOP || pc_I !== 32'h3004) begin n_bad++; $display("FAIL kill_out: got %h/%b pc %h want %h/0 pc 00003004", inst, inst_valid, pc_I, NOP); end
    n_cmp++; if (ic.icache_addr !== 32'h3008) begin n_bad++; $display("FAIL kill_pc: got %h want 00003008", ic.icache_addr); end
    tick(); Inst_Kill = 1'b0; PC_Sel = 2'd1; alu_target = 32'h2008; #1;
    n_cmp++; if (inst !== 32'h3008 || inst_valid !== 1'b1) begin n_bad++; $display("FAIL kill_after: got %h/%b want 00003008/1", inst, inst_valid); end
    n_cmp++; if (ic.icache_addr !== 32'h2008) begin n_bad++; $display("FAIL kill_redir: got %h want 00002008", ic.icache_addr); end
  endtask

  task automatic test_redirect_in_miss();
    tick(); PC_Sel = 2'd0; force_miss = 1'b1; #1;
    n_cmp++; if (inst !== 32'h2008 || inst_valid !== 1'b1) begin n_bad++; $display("FAIL rm_pre: got %h/%b want 00002008/1", inst, inst_valid); end
    tick(); #1;
    n_cmp++; if (inst_valid !== 1'b0 || ic.icache_addr !== 32'h200C) begin n_bad++; $display("FAIL rm_miss: got v %b addr %h want v 0 addr 0000200c", inst_valid, ic.icache_addr); end
    tick(); PC_Sel = 2'd1; alu_target = 32'h4000; force_miss = 1'b0; #1;
    n_cmp++; if (inst_valid !== 1'b0 || ic.icache_addr !== 32'h200C) begin n_bad++; $display("FAIL rm_latch: got v %b addr %h want v 0 addr 0000200c", inst_valid, ic.icache_addr); end
    tick(); PC_Sel = 2'd0; alu_target = 32'd0; #1;
    n_cmp++; if (inst_valid !== 1'b0 || inst !== NOP) begin n_bad++; $display("FAIL rm_discard: got %h/%b want %h/0", inst, inst_valid, NOP); end
    n_cmp++; if (ic.icache_addr !== 32'h4000) begin n_bad++; $display("FAIL rm_target_addr: got %h want 00004000", ic.icache_addr); end
    tick(); #1;
    n_cmp++; if (pc_I !== 32'h4000 || inst !== 32'h4000 || inst_valid !== 1'b1) begin n_bad++; $display("FAIL rm_target: got %h pc %h v %b want 00004000 pc 00004000 v 1", inst, pc_I, inst_valid); end
  endtask

  task automatic test_wrap();
    tick(); PC_Sel = 2'd1; alu_target = 32'hFFFF_FFFE; #1;
    n_cmp++; if (inst !== 32'h4004 || inst_valid !== 1'b1) begin n_bad++; $display("FAIL wrap_pre: got %h/%b want 00004004/1", inst, inst_valid); end
    n_cmp++; if (ic.icache_addr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_align: got %h want fffffffc", ic.icache_addr); end
    tick(); PC_Sel = 2'd0; alu_target = 32'd0; #1;
    n_cmp++; if (pc_I !== 32'hFFFF_FFFC || inst !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_top: got %h pc %h want fffffffc pc fffffffc", inst, pc_I); end
    n_cmp++; if (ic.icache_addr !== 32'h0) begin n_bad++; $display("FAIL wrap_addr: got %h want 00000000", ic.icache_addr); end
    tick(); #1;
    n_cmp++; if (pc_I !== 32'h0 || inst_valid !== 1'b1 || ic.icache_addr !== 32'h4) begin n_bad++; $display("FAIL wrap_zero: got pc %h v %b addr %h want pc 00000000 v 1 addr 00000004", pc_I, inst_valid, ic.icache_addr); end
  endtask

  task automatic test_kill_stall();
    tick(); stall = 1'b1; Inst_Kill = 1'b1; #1;
    n_cmp++; if (inst_valid !== 1'b0 || pc_I !== 32'h4 || ic.icache_addr !== 32'h4) begin n_bad++; $display("FAIL ks_first: got v %b pc %h addr %h want v 0 pc 00000004 addr 00000004", inst_valid, pc_I, ic.icache_addr); end
    tick(); Inst_Kill = 1'b0; #1;
    n_cmp++; if (inst_valid !== 1'b0 || inst !== NOP || pc_I !== 32'h4) begin n_bad++; $display("FAIL ks_held: got %h/%b pc %h want %h/0 pc 00000004", inst, inst_valid, pc_I, NOP); end
    tick(); stall = 1'b0; #1;
    n_cmp++; if (inst_valid !== 1'b0 || ic.icache_addr !== 32'h8) begin n_bad++; $display("FAIL ks_exit: got v %b addr %h want v 0 addr 00000008", inst_valid, ic.icache_addr); end
    tick(); #1;
    n_cmp++; if (inst !== 32'h8 || inst_valid !== 1'b1) begin n_bad++; $display("FAIL ks_after: got %h/%b want 00000008/1", inst, inst_valid); end
  endtask

  task automatic test_reset_in_hold();
    tick(); stall = 1'b1; #1;
    n_cmp++; if (inst !== 32'hC || inst_valid !== 1'b1) begin n_bad++; $display("FAIL rh_enter: got %h/%b want 0000000c/1", inst, inst_valid); end
    tick(); #1;
    n_cmp++; if (inst !== 32'hC || pc_I !== 32'hC || inst_valid !== 1'b1) begin n_bad++; $display("FAIL rh_hold: got %h pc %h v %b want 0000000c pc 0000000c v 1", inst, pc_I, inst_valid); end
`ifdef FETCH_PERF_EN
    n_cmp++; if (fetch_count !== 32'd13) begin n_bad++; $display("FAIL perf_fetch: got %0d want 13", fetch_count); end
    n_cmp++; if (kill_count !== 32'd3) begin n_bad++; $display("FAIL perf_kill: got %0d want 3", kill_count); end
`endif
    #2; reset = 1'b1; #1;
    n_cmp++; if (inst !== NOP || pc_I !== 32'h2000 || inst_valid !== 1'b0) begin n_bad++; $display("FAIL rh_async: got %h pc %h v %b want %h pc 00002000 v 0", inst, pc_I, inst_valid, NOP); end
    n_cmp++; if (ic.icache_re !== 1'b0 || ic.icache_addr !== 32'h2000) begin n_bad++; $display("FAIL rh_bus: got re %b addr %h want re 0 addr 00002000", ic.icache_re, ic.icache_addr); end
`ifdef FETCH_PERF_EN
    n_cmp++; if (fetch_count !== 32'd0 || kill_count !== 32'd0) begin n_bad++; $display("FAIL rh_perf: got %0d/%0d want 0/0", fetch_count, kill_count); end
`endif
    tick(); reset = 1'b0; stall = 1'b0; #1;
    n_cmp++; if (inst_valid !== 1'b0 || ic.icache_addr !== 32'h2000 || ic.icache_re !== 1'b1) begin n_bad++; $display("FAIL rh_boot: got v %b addr %h re %b want v 0 addr 00002000 re 1", inst_valid, ic.icache_addr, ic.icache_re); end
    tick(); #1;
    n_cmp++; if (inst !== 32'h2000 || inst_valid !== 1'b1 || ic.icache_addr !== 32'h2004) begin n_bad++; $display("FAIL rh_restart: got %h/%b addr %h want 00002000/1 addr 00002004", inst, inst_valid, ic.icache_addr); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_miss();
    test_stall();
    test_redirect();
    test_kill();
    test_redirect_in_miss();
    test_wrap();
    test_kill_stall();
    test_reset_in_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: time %0t exceeded limit 20000", $time);
    $fatal(1);
  end
endmodule
